// File: rtl/ia_pkg.sv
// Shared types for the input-activation fetch unit: FSM states, fetch mode
// encoding and the lane-index width helper.
package ia_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } ia_state_e;

  typedef enum logic {
    IA_GATHER = 1'b0,
    IA_BCAST  = 1'b1
  } ia_mode_e;

  function automatic int unsigned ia_lane_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ia_lane_assembler.sv
// Assembly slots for one activation vector. Returning words land in their lane
// (or in every lane when broadcasting); vec_o already includes this cycle's word.
module ia_lane_assembler import ia_pkg::*; #(
  parameter int unsigned LANE_WIDTH = 4352,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LIW        = ia_lane_w(NUM_LANES)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            wr_en_i,
  input  logic [LIW-1:0]                  wr_lane_i,
  input  logic                            wr_bcast_i,
  input  logic                            wr_last_i,
  input  logic [LANE_WIDTH-1:0]           wr_data_i,
  input  logic                            take_i,
  output logic [LANE_WIDTH*NUM_LANES-1:0] vec_o,
  output logic                            avail_o,
  output logic                            complete_o
);

  logic [LANE_WIDTH-1:0] slot_q [NUM_LANES];
  logic [LANE_WIDTH-1:0] slot_d [NUM_LANES];
  logic                  complete_q;
  logic                  complete_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      slot_d[i] = slot_q[i];
      if (wr_en_i && (wr_bcast_i || (wr_lane_i == LIW'(i)))) begin
        slot_d[i] = wr_data_i;
      end
    end
  end

  // Lane 0 sits in the most significant bits of the vector.
  always_comb begin
    vec_o = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      vec_o[(NUM_LANES-1-i)*LANE_WIDTH +: LANE_WIDTH] = slot_d[i];
    end
  end

  always_comb begin
    complete_d = complete_q;
    if (take_i) begin
      complete_d = 1'b0;
    end else if (wr_en_i && wr_last_i) begin
      complete_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        slot_q[i] <= '0;
      end
      complete_q <= 1'b0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        slot_q[i] <= '0;
      end
      complete_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          slot_q[i] <= slot_d[i];
        end
      end
      complete_q <= complete_d;
    end
  end

  assign avail_o    = complete_q | (wr_en_i & wr_last_i);
  assign complete_o = complete_q;

endmodule

// File: rtl/ia_fetch_unit.sv
// Input-activation fetch unit: sequences BRAM reads, gathers or broadcasts words
// into a wide vector and hands it to the PE array over valid/ready.
module ia_fetch_unit import ia_pkg::*; #(
  parameter int unsigned LANE_WIDTH  = 4352,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            mode,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_vectors,
  output logic                            busy,
  output logic                            done,
  output logic                            mem_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [LANE_WIDTH-1:0]           mem_rdata,
  output logic                            ia_valid,
  input  logic                            ia_ready,
  output logic [LANE_WIDTH*NUM_LANES-1:0] ia_data,
  output logic                            ia_last
);

  localparam int unsigned LIW = ia_lane_w(NUM_LANES);
  localparam logic [ADDR_WIDTH:0]   VEC_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LIW-1:0]        LANE_MAX = LIW'(NUM_LANES - 1);
  localparam logic [LIW-1:0]        LANE_ONE = {{(LIW-1){1'b0}}, 1'b1};

  ia_state_e             state_q, state_d;
  ia_mode_e              mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   vec_left_q, vec_left_d;
  logic [LIW-1:0]        word_idx_q, word_idx_d;
  logic [1:0]            owed_q, owed_d;

  logic [MEM_LATENCY-1:0] tag_vld_q, tag_wlast_q, tag_vlast_q;
  logic [LIW-1:0]         tag_lane_q [MEM_LATENCY];

  logic                            out_valid_q;
  logic [LANE_WIDTH*NUM_LANES-1:0] out_data_q;
  logic                            out_last_q;
  logic                            asm_vlast_q;

  logic       issue, first_issue, word_last, vec_final, hs, clear, load;
  logic       credit_ok;
  logic [1:0] owed_next;
  logic       ret_vld, ret_wlast, ret_vlast;
  logic [LIW-1:0] ret_lane;
  logic [LANE_WIDTH*NUM_LANES-1:0] asm_vec;
  logic       asm_avail, asm_complete;

  assign issue       = (state_q == ST_FETCH);
  assign first_issue = issue && (word_idx_q == '0);
  assign word_last   = (mode_q == IA_BCAST) || (word_idx_q == LANE_MAX);
  assign vec_final   = (vec_left_q == VEC_ONE);
  assign hs          = out_valid_q && ia_ready;
  assign clear       = (state_q == ST_IDLE) && start;

  // A vector holds a credit from its first read until its output handshake.
  // Two credits cover the output register plus the assembly slot, so a new
  // vector is only started when both can never be occupied at its return.
  assign owed_next = owed_q + {1'b0, first_issue} - {1'b0, hs};
  assign credit_ok = (owed_next < 2'd2);

  assign ret_vld   = tag_vld_q[MEM_LATENCY-1];
  assign ret_wlast = tag_wlast_q[MEM_LATENCY-1];
  assign ret_vlast = tag_vlast_q[MEM_LATENCY-1];
  assign ret_lane  = tag_lane_q[MEM_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    vec_left_d = vec_left_q;
    word_idx_d = word_idx_q;
    owed_d     = owed_next;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = ia_mode_e'(mode);
          addr_d     = base_addr;
          vec_left_d = num_vectors;
          word_idx_d = '0;
          state_d    = (num_vectors == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        addr_d = addr_q + ADDR_ONE;
        if (word_last) begin
          word_idx_d = '0;
          vec_left_d = vec_left_q - VEC_ONE;
          if (vec_final) begin
            state_d = ST_DRAIN;
          end else if (!credit_ok) begin
            state_d = ST_HOLD;
          end
        end else begin
          word_idx_d = word_idx_q + LANE_ONE;
        end
      end
      ST_HOLD: begin
        if (credit_ok) begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (hs && out_last_q) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= IA_GATHER;
      addr_q     <= '0;
      vec_left_q <= '0;
      word_idx_q <= '0;
      owed_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      vec_left_q <= vec_left_d;
      word_idx_q <= word_idx_d;
      owed_q     <= owed_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld_q   <= '0;
      tag_wlast_q <= '0;
      tag_vlast_q <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        tag_lane_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = MEM_LATENCY - 1; i > 0; i--) begin
        tag_vld_q[i]   <= tag_vld_q[i-1];
        tag_wlast_q[i] <= tag_wlast_q[i-1];
        tag_vlast_q[i] <= tag_vlast_q[i-1];
        tag_lane_q[i]  <= tag_lane_q[i-1];
      end
      tag_vld_q[0]   <= issue;
      tag_wlast_q[0] <= issue && word_last;
      tag_vlast_q[0] <= issue && word_last && vec_final;
      tag_lane_q[0]  <= (mode_q == IA_BCAST) ? '0 : word_idx_q;
    end
  end

  assign load = asm_avail && (!out_valid_q || ia_ready);

  ia_lane_assembler #(
    .LANE_WIDTH (LANE_WIDTH),
    .NUM_LANES  (NUM_LANES),
    .LIW        (LIW)
  ) u_asm (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (clear),
    .wr_en_i    (ret_vld),
    .wr_lane_i  (ret_lane),
    .wr_bcast_i (mode_q == IA_BCAST),
    .wr_last_i  (ret_wlast),
    .wr_data_i  (mem_rdata),
    .take_i     (load),
    .vec_o      (asm_vec),
    .avail_o    (asm_avail),
    .complete_o (asm_complete)
  );

  // A vector completing while the output register is busy parks in the slots;
  // its final-vector flag parks here alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_vlast_q <= 1'b0;
    end else if (clear) begin
      asm_vlast_q <= 1'b0;
    end else if (ret_vld && ret_wlast && !load) begin
      asm_vlast_q <= ret_vlast;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= asm_vec;
      out_last_q  <= asm_complete ? asm_vlast_q : ret_vlast;
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign ia_valid = out_valid_q;
  assign ia_data  = out_data_q;
  assign ia_last  = out_last_q;

endmodule

// File: tb/tb_ia_fetch_unit.sv
// Randomised and directed bench for ia_fetch_unit with a queue-based scoreboard
// and a BRAM model holding mem[a] = 8'hA0 + a.
module tb_ia_fetch_unit;

  localparam int unsigned LW    = 8;
  localparam int unsigned NL    = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned ML    = 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_vectors = '0;
  logic              busy, done, mem_en, ia_valid, ia_last;
  logic [AW-1:0]     mem_addr;
  logic [LW-1:0]     mem_rdata;
  logic              ia_ready;
  logic [LW*NL-1:0]  ia_data;

  int tests = 0;
  int fails = 0;
  int unsigned rdy_mode = 0;

  logic [LW-1:0]    mem [DEPTH];
  logic [LW-1:0]    rd_pipe [ML];
  logic [LW*NL-1:0] exp_data_q [$];
  bit               exp_last_q [$];
  logic [AW-1:0]    exp_addr_q [$];

  ia_fetch_unit #(
    .LANE_WIDTH  (LW),
    .NUM_LANES   (NL),
    .ADDR_WIDTH  (AW),
    .MEM_LATENCY (ML)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .base_addr   (base_addr),
    .num_vectors (num_vectors),
    .busy        (busy),
    .done        (done),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .ia_valid    (ia_valid),
    .ia_ready    (ia_ready),
    .ia_data     (ia_data),
    .ia_last     (ia_last)
  );

  always #5 clock = ~clock;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = LW'(8'hA0 + i);
  end

  // BRAM model: garbage is returned on cycles without a read.
  always @(posedge clock) begin
    rd_pipe[0] <= mem_en ? mem[mem_addr] : LW'($urandom);
    for (int i = 1; i < int'(ML); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[ML-1];

  initial begin
    ia_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: ia_ready = 1'b1;
        1: ia_ready = 1'($urandom % 2);
        default: ia_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every read address and every presented vector is checked against the queues.
  logic [AW-1:0]    mon_addr;
  always @(negedge clock) begin
    if (reset) begin
      if (mem_en) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL mem_addr got=%0d exp=none", mem_addr);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          if (mem_addr !== mon_addr) begin
            fails++;
            $display("FAIL mem_addr got=%0d exp=%0d", mem_addr, mon_addr);
          end
        end
      end
      if (ia_valid) begin
        tests++;
        if (exp_data_q.size() == 0) begin
          fails++;
          $display("FAIL ia_data got=%h exp=none", ia_data);
        end else begin
          if (ia_data !== exp_data_q[0] || ia_last !== exp_last_q[0]) begin
            fails++;
            $display("FAIL ia_data got=%h last=%b exp=%h last=%b",
                     ia_data, ia_last, exp_data_q[0], exp_last_q[0]);
          end
          if (ia_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_exp(input bit m, input int unsigned base, input int unsigned n);
    int unsigned w;
    logic [LW*NL-1:0] v;
    w = m ? 1 : NL;
    for (int unsigned k = 0; k < n; k++) begin
      v = '0;
      for (int unsigned l = 0; l < NL; l++) begin
        v = (v << LW) | (LW*NL)'(mem[(base + k*w + (m ? 0 : l)) % DEPTH]);
      end
      exp_data_q.push_back(v);
      exp_last_q.push_back(k == n - 1);
      for (int unsigned j = 0; j < w; j++) exp_addr_q.push_back(AW'((base + k*w + j) % DEPTH));
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_cmd(input bit m, input int unsigned base, input int unsigned n,
                         input bit chk, input bit busy_start, input int unsigned stall,
                         input bit rnd_rdy);
    int unsigned w, cyc, nen, ndone, stall_exp;
    int first_v, done_cyc;
    w = m ? 1 : NL;
    push_exp(m, base, n);
    @(negedge clock);
    rdy_mode = (stall > 0) ? 2 : (rnd_rdy ? 1 : 0);
    if (stall > 0) ia_ready = 1'b0;
    start = 1'b1;
    mode = m;
    base_addr = AW'(base);
    num_vectors = (AW+1)'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
    mode = 1'($urandom);
    base_addr = AW'($urandom);
    num_vectors = (AW+1)'($urandom);
    cyc = 0; nen = 0; ndone = 0; first_v = -1; done_cyc = -1;
    while (cyc < 400 && !(done_cyc >= 0 && int'(cyc) >= done_cyc + 2)) begin
      @(negedge clock);
      cyc++;
      if (mem_en) nen++;
      if (ia_valid && first_v < 0) first_v = int'(cyc);
      if (cyc == 1) check("busy_after_start", int'(busy), 1);
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = int'(cyc);
          check("busy_at_done", int'(busy), 1);
        end
      end
      if (busy_start && cyc == 3) start = 1'b1;
      if (busy_start && cyc == 4) start = 1'b0;
      if (stall > 0 && cyc == stall) begin
        stall_exp = ((n < 2) ? n : 2) * w;
        check("stall_reads", int'(nen), int'(stall_exp));
        check("stall_valid", int'(ia_valid), int'(n > 0));
        rdy_mode = rnd_rdy ? 1 : 0;
      end
    end
    check("done_count", int'(ndone), 1);
    check("read_count", int'(nen), int'(n * w));
    check("drained", int'(exp_data_q.size() + exp_addr_q.size()) + int'(busy), 0);
    if (chk) begin
      check("first_valid_cycle", first_v, (n == 0) ? -1 : int'(w + ML + 1));
      if (n == 0 || !m) check("done_cycle", done_cyc, (n == 0) ? 1 : int'(w*n + ML + 2));
    end
    exp_data_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    rdy_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_outputs", int'({busy, done, mem_en, ia_valid, ia_last}) + int'(mem_addr) + int'(ia_data != '0), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_cmd(1'b0, 2, 2, 1'b1, 1'b0, 0, 1'b0);   // gather basic
    run_cmd(1'b1, 7, 3, 1'b1, 1'b0, 0, 1'b0);   // broadcast
    run_cmd(1'b0, 30, 1, 1'b1, 1'b0, 0, 1'b0);  // address wrap
    run_cmd(1'b0, 4, 3, 1'b0, 1'b0, 20, 1'b0);  // backpressure
    run_cmd(1'b0, 9, 0, 1'b1, 1'b0, 0, 1'b0);   // zero vectors
    run_cmd(1'b0, 20, 3, 1'b1, 1'b1, 0, 1'b0);  // start while busy

    // Reset in the middle of the second vector.
    push_exp(1'b0, 12, 4);
    @(negedge clock);
    start = 1'b1; mode = 1'b0; base_addr = AW'(12); num_vectors = (AW+1)'(4);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("reset_mid_outputs", int'({busy, done, mem_en, ia_valid, ia_last}) + int'(mem_addr) + int'(ia_data != '0), 0);
    exp_data_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_cmd(1'b0, 13, 2, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(1'b1, 31, 2, 1'b1, 1'b0, 0, 1'b0);

    for (int unsigned t = 0; t < 12; t++) begin
      run_cmd(1'($urandom % 2), $urandom % DEPTH, $urandom_range(0, 5), 1'b0, 1'b0, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
